// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch front-end definitions: architectural widths, reset PC default and the queue FSM states.
`default_nettype none
package riscv_fetch_pkg;
   localparam int          XLEN             = 32;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      DISCARD = 1'b1
   } fetch_state_e;
endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry {pc, instr} FIFO with synchronous clear and simultaneous push/pop.
`default_nettype none
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_push,
   input  logic [XLEN-1:0] i_push_pc,
   input  logic [XLEN-1:0] i_push_instr,
   input  logic            i_pop,
   output logic [CW-1:0]   o_count,
   output logic [XLEN-1:0] o_head_pc,
   output logic [XLEN-1:0] o_head_instr
);
   import riscv_fetch_pkg::*;

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [XLEN-1:0] r_pc    [DEPTH];
   logic [XLEN-1:0] r_instr [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   // Pointers wrap explicitly so non-power-of-two depths stay in range.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= f_inc(r_tail);
         if (i_pop)  r_head <= f_inc(r_head);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_clear && i_push) begin
         r_pc[r_tail]    <= i_push_pc;
         r_instr[r_tail] <= i_push_instr;
      end
   end

   assign o_count      = r_count;
   assign o_head_pc    = r_pc[r_head];
   assign o_head_instr = r_instr[r_head];
endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: credit-limited sequential instruction prefetcher with redirect flush
// and discard of stale in-flight responses.
`default_nettype none
module fetch_prefetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = riscv_fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_fetch_pkg::RESET_PC_DEFAULT)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_req_ready,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic            out_valid,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   input  logic            out_ready
);
   import riscv_fetch_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;
   fetch_state_e    r_state;

   fetch_state_e    w_next_state;
   logic [CW-1:0]   w_drop_nxt;
   logic [CW-1:0]   w_outstanding_nxt;
   logic [CW-1:0]   w_count;
   logic [XLEN-1:0] w_head_pc;
   logic [XLEN-1:0] w_head_instr;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_credit;
   logic            w_req_hs;
   logic            w_rsp_hs;
   logic            w_redir;
   logic            w_accept_rsp;
   logic            w_push;
   logic            w_pop;

   // Buffered plus in-flight fetches never exceed DEPTH, so a push always finds room.
   assign w_credit      = ({1'b0, w_count} + {1'b0, r_outstanding}) < (CW + 1)'(DEPTH);
   assign mem_req_valid = reset & w_credit;
   assign mem_req_addr  = reset ? r_fetch_pc : RESET_PC;

   assign w_req_hs          = mem_req_valid & mem_req_ready;
   assign w_rsp_hs          = reset & mem_rsp_valid;
   assign w_redir           = reset & redirect_valid;
   assign w_redirect_pc     = redirect_pc & ~XLEN'(3);
   assign w_outstanding_nxt = r_outstanding + CW'(w_req_hs) - CW'(w_rsp_hs);

   always_ff @(posedge clock) begin
      if (!reset) r_state <= RUN;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_drop_nxt   = r_drop_cnt;
      if (w_redir) begin
         w_drop_nxt   = w_outstanding_nxt;
         w_next_state = (w_outstanding_nxt != '0) ? DISCARD : RUN;
      end else if (r_state == DISCARD && w_rsp_hs) begin
         w_drop_nxt = r_drop_cnt - CW'(1);
         if (r_drop_cnt == CW'(1)) w_next_state = RUN;
      end
   end

   always_comb begin
      w_accept_rsp = (r_state == RUN);
   end

   assign w_push = w_rsp_hs & w_accept_rsp & ~w_redir;
   assign w_pop  = out_valid & out_ready & ~w_redir;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         r_drop_cnt    <= w_drop_nxt;
         if (w_redir) begin
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
         end else begin
            if (w_req_hs) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
            if (w_push)   r_rsp_pc   <= r_rsp_pc + XLEN'(INSTR_BYTES);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN),
      .CW    (CW)
   ) u_fifo (
      .i_clk        (clock),
      .i_rst_n      (reset),
      .i_clear      (w_redir),
      .i_push       (w_push),
      .i_push_pc    (r_rsp_pc),
      .i_push_instr (mem_rsp_data),
      .i_pop        (w_pop),
      .o_count      (w_count),
      .o_head_pc    (w_head_pc),
      .o_head_instr (w_head_instr)
   );

   assign out_valid = reset & (w_count != '0);
   assign out_pc    = out_valid ? w_head_pc    : '0;
   assign out_instr = out_valid ? w_head_instr : '0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
// Directed, cycle-by-cycle vector bench for fetch_prefetch_queue (DEPTH=4, RESET_PC=0).
`default_nettype none
module tb_fetch_prefetch_queue;
   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;

   always #5 clock = ~clock;

   fetch_prefetch_queue #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
   );

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        rq_rdy;
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        o_rdy;
      logic        e_rqv;
      logic [31:0] e_rqa;
      logic        e_ov;
      logic [31:0] e_opc;
      logic [31:0] e_oin;
   } vec_t;

   vec_t vq[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   tb_out = 0;

   // Memory image: word at address a is "addi x(i), x0, 10*i" with i = a/4 + 1.
   function automatic logic [31:0] w(input logic [31:0] a);
      logic [31:0] i;
      i = (a >> 2) + 32'd1;
      return ((i * 32'd10) << 20) | (i << 7) | 32'h13;
   endfunction

   task automatic add(input logic rst, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic rv, input logic [31:0] raddr,
                      input logic ordy, input logic erqv, input logic [31:0] erqa,
                      input logic eov, input logic [31:0] eopc);
      vec_t v;
      v.rst = rst; v.redir = rd; v.rpc = rpc; v.rq_rdy = rdy;
      v.rsp_v = rv; v.rsp_d = rv ? w(raddr) : 32'h0; v.o_rdy = ordy;
      v.e_rqv = erqv; v.e_rqa = erqa; v.e_ov = eov;
      v.e_opc = eov ? eopc : 32'h0;
      v.e_oin = eov ? w(eopc) : 32'h0;
      vq.push_back(v);
   endtask

   // Independent in-flight tracker flags responses with nothing outstanding.
   always @(posedge clock) begin
      if (reset !== 1'b1) begin
         tb_out <= 0;
      end else begin
         if (mem_rsp_valid && tb_out == 0) begin
            $display("FAIL protocol: rsp_valid=1 with outstanding=%0d, required outstanding>0", tb_out);
            n_miss = n_miss + 1;
         end
         tb_out <= tb_out + ((mem_req_valid && mem_req_ready) ? 1 : 0) - (mem_rsp_valid ? 1 : 0);
      end
   end

   initial begin
      reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b0;

      // reset, then 1-cycle latency streaming at one instruction per cycle
      add(0,0,0,0,0,0,0, 0,'h0, 0,0);
      add(0,0,0,0,0,0,0, 0,'h0, 0,0);
      add(1,0,0,1,0,0,1, 1,'h0, 0,0);
      add(1,0,0,1,1,'h0,1, 1,'h4, 0,0);
      add(1,0,0,1,1,'h4,1, 1,'h8, 1,'h0);
      add(1,0,0,1,1,'h8,1, 1,'hC, 1,'h4);
      add(1,0,0,0,1,'hC,1, 1,'h10, 1,'h8);
      add(1,0,0,0,0,0,1, 1,'h10, 1,'hC);
      // backpressure: credit limit stops requests, one pop frees one slot
      add(1,0,0,1,0,0,0, 1,'h10, 0,0);
      add(1,0,0,1,1,'h10,0, 1,'h14, 0,0);
      add(1,0,0,1,1,'h14,0, 1,'h18, 1,'h10);
      add(1,0,0,1,1,'h18,0, 1,'h1C, 1,'h10);
      add(1,0,0,1,1,'h1C,0, 0,'h20, 1,'h10);
      add(1,0,0,1,0,0,0, 0,'h20, 1,'h10);
      add(1,0,0,1,0,0,1, 0,'h20, 1,'h10);
      add(1,0,0,1,0,0,0, 1,'h20, 1,'h14);
      add(1,0,0,1,0,0,0, 0,'h24, 1,'h14);
      // mid-stream reset with entries buffered, restart at RESET_PC
      add(0,0,0,1,0,0,0, 0,'h0, 0,0);
      add(1,0,0,1,0,0,0, 1,'h0, 0,0);
      add(1,0,0,1,0,0,0, 1,'h4, 0,0);
      add(1,0,0,1,0,0,0, 1,'h8, 0,0);
      // redirect to 0x40 with three requests outstanding
      add(1,1,'h40,0,0,0,0, 1,'hC, 0,0);
      add(1,0,0,1,1,'h0,0, 1,'h40, 0,0);
      add(1,0,0,1,1,'h4,0, 1,'h44, 0,0);
      add(1,0,0,1,1,'h8,0, 1,'h48, 0,0);
      add(1,0,0,0,1,'h40,0, 1,'h4C, 0,0);
      add(1,0,0,0,1,'h44,1, 1,'h4C, 1,'h40);
      add(1,0,0,0,1,'h48,1, 1,'h4C, 1,'h44);
      add(1,0,0,0,0,0,1, 1,'h4C, 1,'h48);
      // redirect to 0x43 coinciding with request handshake, response and pop
      add(1,0,0,1,0,0,1, 1,'h4C, 0,0);
      add(1,0,0,1,1,'h4C,1, 1,'h50, 0,0);
      add(1,1,'h43,1,1,'h50,1, 1,'h54, 1,'h4C);
      add(1,0,0,1,0,0,1, 1,'h40, 0,0);
      add(1,0,0,0,1,'h54,1, 1,'h44, 0,0);
      add(1,0,0,0,1,'h40,1, 1,'h44, 0,0);
      add(1,0,0,0,0,0,1, 1,'h44, 1,'h40);
      // redirect to 0x80, then to 0x100 while still discarding
      add(1,0,0,1,0,0,1, 1,'h44, 0,0);
      add(1,0,0,1,0,0,1, 1,'h48, 0,0);
      add(1,1,'h80,0,0,0,1, 1,'h4C, 0,0);
      add(1,0,0,1,1,'h44,1, 1,'h80, 0,0);
      add(1,1,'h100,1,0,0,1, 1,'h84, 0,0);
      add(1,0,0,0,1,'h48,1, 1,'h100, 0,0);
      add(1,0,0,0,1,'h80,1, 1,'h100, 0,0);
      add(1,0,0,0,1,'h84,1, 1,'h100, 0,0);
      add(1,0,0,1,0,0,1, 1,'h100, 0,0);
      add(1,0,0,0,1,'h100,1, 1,'h104, 0,0);
      add(1,0,0,0,0,0,1, 1,'h104, 1,'h100);
      add(1,0,0,0,0,0,1, 1,'h104, 0,0);

      for (int k = 0; k < vq.size(); k++) begin
         @(negedge clock);
         reset          = vq[k].rst;
         redirect_valid = vq[k].redir;
         redirect_pc    = vq[k].rpc;
         mem_req_ready  = vq[k].rq_rdy;
         mem_rsp_valid  = vq[k].rsp_v;
         mem_rsp_data   = vq[k].rsp_d;
         out_ready      = vq[k].o_rdy;
         #1;
         n_vec = n_vec + 1;
         if ({mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr} !==
             {vq[k].e_rqv, vq[k].e_rqa, vq[k].e_ov, vq[k].e_opc, vq[k].e_oin}) begin
            n_miss = n_miss + 1;
            $display("FAIL vec%0d: got rqv=%0b addr=%h ov=%0b pc=%h instr=%h, want rqv=%0b addr=%h ov=%0b pc=%h instr=%h",
                     k, mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr,
                     vq[k].e_rqv, vq[k].e_rqa, vq[k].e_ov, vq[k].e_opc, vq[k].e_oin);
         end
      end

      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
`default_nettype wire
